fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, reads 16-bit words from instruction memory, drives the IF/ID register.
//  Sits directly downstream of interruptHandler. Passes its injected instruction words into the pipeline in place of memory words.
//  On interruptRaisedToFetch, loads the PC from the interrupt vector table (IVT). On reset, loads the PC from the reset vector.
// PARAMETERS
//  PC_W       32      PC width; word-addressed.
//  INSTR_W    16      instruction word width.
//  ADDR_W     20      imem address width; imem_addr = pc[ADDR_W-1:0].
//  RESET_VEC  0       word address of 2-word reset vector (high word first).
//  IVT_ADDR   2       word address of 2-word interrupt vector (high word first).
// PORTS
//  clk            in   1        clock; all state updates on posedge.
//  rst            in   1        synchronous, active-high reset.
//  imem_addr      out  ADDR_W   instruction memory address (combinational from state/pc).
//  imem_rdata     in   INSTR_W  memory word, valid same cycle (async read).
//  stall          in   1        hazard stall: hold pc and IF/ID outputs.
//  flush          in   1        taken branch/jump: redirect pc.
//  branch_target  in   PC_W     redirect address, sampled when flush=1.
//  int_inject     in   1        interruptRaisedInstruction: int_instr replaces the fetched word.
//  int_instr      in   INSTR_W  interruptInstruction word from the handler.
//  int_to_fetch   in   1        interruptRaisedToFetch: start the IVT vector load.
//  if_instr       out  INSTR_W  IF/ID instruction (registered).
//  if_pc          out  PC_W     PC associated with if_instr (registered).
//  if_valid       out  1        1 = if_instr is a real/injected instruction; 0 = bubble.
//  int_ret_pc     out  PC_W     return PC for the interrupt (see CONFIGURATION).
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=BOOT_HI, pc=0, if_instr=BUBBLE (16'h07F8), if_pc=0, if_valid=0, int_ret_pc=0.
//  FSM states: BOOT_HI, BOOT_LO, RUN, VEC_HI, VEC_LO.
//   BOOT_HI: imem_addr=RESET_VEC; pc[31:16]<=rdata; next state BOOT_LO.
//   BOOT_LO: imem_addr=RESET_VEC+1; pc[15:0]<=rdata; next state RUN.
//   VEC_HI/VEC_LO: same sequence at IVT_ADDR and IVT_ADDR+1; next state RUN.
//   In BOOT_*/VEC_*: outputs BUBBLE with valid=0; stall, flush, int_inject and int_to_fetch are ignored.
//  RUN: imem_addr=pc[ADDR_W-1:0]. Priority per cycle, highest first:
//   1 flush:        pc<=branch_target; IF/ID<=BUBBLE, valid 0.
//   2 int_to_fetch: next state VEC_HI; IF/ID<=BUBBLE, valid 0; pc is not updated.
//   3 stall:        pc, if_instr, if_pc and if_valid all hold.
//   4 int_inject:   if_instr<=int_instr; if_pc<=pc; valid 1; pc holds, so no memory word is consumed.
//   5 normal:       if_instr<=imem_rdata; if_pc<=pc; valid 1; pc<=pc+1.
//  Latency: 1 cycle from imem_addr to if_instr.
//   First post-reset instruction appears 3 cycles after rst deasserts.
//   First ISR instruction appears 3 cycles after int_to_fetch.
//  pc+1 wraps modulo 2^PC_W; no overflow flag.
//  Reset mid-operation (any state) returns the FSM to BOOT_HI; a partial vector load is discarded.
//  int_to_fetch is a 1-cycle pulse. A second pulse while in VEC_* is ignored.
// CONFIGURATION
//  INT_RET_PC_EN defined: int_ret_pc<=pc on the first RUN cycle where int_inject rises (0->1) and neither flush nor stall is active.
//   The value is held until the next such rise. This is the PC the ISR returns to.
//  INT_RET_PC_EN undefined: int_ret_pc is tied to 0; no capture register is built.
// STRUCTURE
//  Package fetch_pkg holds:
//   - BUBBLE_INSTR = 16'h07F8.
//   - the fetch_state_t encoding (BOOT_HI=0, BOOT_LO=1, RUN=2, VEC_HI=3, VEC_LO=4).
//  Sub-module fetch_pc_reg: PC register with hi/lo half-load, full load, increment and hold.
//   FSM and IF/ID mux stay in fetch_unit.
// TESTING
//  T1 boot: mem[0]=16'h0000, mem[1]=16'h0020, mem[0x20]=16'hA123; release rst
//     -> if_instr=A123, if_pc=0x20, valid=1 on the 3rd posedge after release.
//  T2 stall: in RUN, hold stall=1 for 3 cycles
//     -> if_instr, if_pc and pc are unchanged; fetching resumes at the next sequential pc.
//  T3 flush with stall: at pc=0x25 assert flush=1, stall=1, branch_target=0x40
//     -> flush wins; one bubble (valid=0); next instruction has if_pc=0x40.
//  T4 inject: at pc=0x30, int_inject=1 for 3 cycles with int_instr=07F8, F480, 0xC000
//     -> those three words appear in order with if_pc=0x30; pc stays 0x30.
//     -> with INT_RET_PC_EN, int_ret_pc=0x30.
//  T5 vector: mem[2]=16'h0000, mem[3]=16'h0100; pulse int_to_fetch
//     -> 3 bubbles, then if_pc=0x100; a flush during VEC_* is ignored.
//  T6 reset mid-vector: assert rst while in VEC_LO
//     -> all outputs return to reset values; boot sequence repeats from RESET_VEC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, bubble encoding and fetch FSM states for the fetch stage
package fetch_pkg;
   localparam int PC_W = 32;
   localparam int INSTR_W = 16;
   localparam int ADDR_W = 20;
   localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 16'h07F8;
   typedef enum logic [2:0] {
      BOOT_HI = 3'd0,
      BOOT_LO = 3'd1,
      RUN     = 3'd2,
      VEC_HI  = 3'd3,
      VEC_LO  = 3'd4
   } fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem, hazard, interrupt and IF/ID signals of the fetch stage
interface fetch_if;
   import fetch_pkg::*;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               stall;
   logic               flush;
   logic [PC_W-1:0]    branch_target;
   logic               int_inject;
   logic [INSTR_W-1:0] int_instr;
   logic               int_to_fetch;
   logic [INSTR_W-1:0] if_instr;
   logic [PC_W-1:0]    if_pc;
   logic               if_valid;
   logic [PC_W-1:0]    int_ret_pc;
   modport master (
      output imem_addr, if_instr, if_pc, if_valid, int_ret_pc,
      input  imem_rdata, stall, flush, branch_target, int_inject, int_instr, int_to_fetch
   );
   modport slave (
      input  imem_addr, if_instr, if_pc, if_valid, int_ret_pc,
      output imem_rdata, stall, flush, branch_target, int_inject, int_instr, int_to_fetch
   );
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with hi/lo half-load, full load, increment and hold
module fetch_pc_reg
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_ld_hi,
   input  logic            i_ld_lo,
   input  logic            i_ld,
   input  logic            i_inc,
   input  logic [15:0]     i_half,
   input  logic [PC_W-1:0] i_target,
   output logic [PC_W-1:0] o_pc
);
   logic [PC_W-1:0] r_pc;
   always_ff @(posedge clk)
      if (rst) r_pc <= '0;
      else if (i_ld_hi) r_pc[31:16] <= i_half;
      else if (i_ld_lo) r_pc[15:0] <= i_half;
      else if (i_ld) r_pc <= i_target;
      else if (i_inc) r_pc <= r_pc + 1'b1;
   assign o_pc = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: boot/IVT vector loading, PC sequencing and IF/ID register; INT_RET_PC_EN adds the ISR return-PC capture
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] IVT_ADDR  = 20'd2
) (
   input logic      clk,
   input logic      rst,
   fetch_if.master  bus
);
   fetch_state_t       r_state;
   logic [INSTR_W-1:0] r_instr;
   logic [PC_W-1:0]    r_if_pc;
   logic               r_valid;
   logic [PC_W-1:0]    w_pc;
   logic               w_run, w_hi, w_lo, w_inc;
   logic [ADDR_W-1:0]  w_base;
   always_comb begin
      w_run  = r_state == RUN;
      w_hi   = r_state == BOOT_HI || r_state == VEC_HI;
      w_lo   = r_state == BOOT_LO || r_state == VEC_LO;
      w_base = (r_state == BOOT_HI || r_state == BOOT_LO) ? RESET_VEC : IVT_ADDR;
      w_inc  = w_run && !bus.flush && !bus.int_to_fetch && !bus.stall && !bus.int_inject;
   end
   assign bus.imem_addr = w_run ? w_pc[ADDR_W-1:0] : w_base + ADDR_W'(w_lo);
   fetch_pc_reg u_pc (
      .clk      (clk),
      .rst      (rst),
      .i_ld_hi  (w_hi),
      .i_ld_lo  (w_lo),
      .i_ld     (w_run && bus.flush),
      .i_inc    (w_inc),
      .i_half   (bus.imem_rdata),
      .i_target (bus.branch_target),
      .o_pc     (w_pc)
   );
   always_ff @(posedge clk)
      if (rst) begin
         r_state <= BOOT_HI;
         r_instr <= BUBBLE_INSTR;
         r_if_pc <= '0;
         r_valid <= 1'b0;
      end else if (!w_run) begin
         r_state <= r_state == BOOT_HI ? BOOT_LO : r_state == VEC_HI ? VEC_LO : RUN;
         r_instr <= BUBBLE_INSTR;
         r_valid <= 1'b0;
      end else if (bus.flush || bus.int_to_fetch) begin
         r_state <= bus.flush ? RUN : VEC_HI;
         r_instr <= BUBBLE_INSTR;
         r_valid <= 1'b0;
      end else if (!bus.stall) begin
         r_instr <= bus.int_inject ? bus.int_instr : bus.imem_rdata;
         r_if_pc <= w_pc;
         r_valid <= 1'b1;
      end
   assign bus.if_instr = r_instr;
   assign bus.if_pc    = r_if_pc;
   assign bus.if_valid = r_valid;
`ifdef INT_RET_PC_EN
   logic            r_inj_d;
   logic [PC_W-1:0] r_ret_pc;
   always_ff @(posedge clk)
      if (rst) begin
         r_inj_d  <= 1'b0;
         r_ret_pc <= '0;
      end else begin
         r_inj_d <= bus.int_inject;
         if (w_run && bus.int_inject && !r_inj_d && !bus.flush && !bus.stall) r_ret_pc <= w_pc;
      end
   assign bus.int_ret_pc = r_ret_pc;
`else
   assign bus.int_ret_pc = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand sequences and randomized model check for fetch_unit (INT_RET_PC_EN aware)
module tb_fetch_unit;
   import fetch_pkg::*;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   logic [15:0] mem [0:4095];
   fetch_if bus ();
   fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
   assign bus.imem_rdata = mem[bus.imem_addr[11:0]];
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        flush;
      logic [31:0] tgt;
      logic        inj;
      logic [15:0] ins;
      logic        tf;
      logic [19:0] addr;
      logic [15:0] e_ins;
      logic [31:0] e_pc;
      logic        e_v;
   } vec_t;
   vec_t tv [21];

   int          m_cnt;
   logic [19:0] m_base;
   logic [31:0] m_pc, m_ipc, m_ret;
   logic [15:0] m_ins;
   logic        m_v, m_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic st, input logic fl, input logic [31:0] tg,
                        input logic ij, input logic [15:0] ii, input logic tf);
      rst = r; bus.stall = st; bus.flush = fl; bus.branch_target = tg;
      bus.int_inject = ij; bus.int_instr = ii; bus.int_to_fetch = tf;
   endtask

   function automatic logic [19:0] m_addr();
      return m_cnt == 0 ? m_pc[19:0] : m_base + 20'(2 - m_cnt);
   endfunction

   // reference: a vector load is a 2-word countdown; RUN applies the priority list directly
   task automatic model_step();
      logic [15:0] w;
      if (rst) begin
         m_cnt = 2; m_base = 20'h0; m_pc = 0; m_ins = BUBBLE_INSTR; m_ipc = 0; m_v = 0; m_ret = 0; m_prev = 0;
      end else begin
         if (m_cnt > 0) begin
            w = mem[m_addr() & 20'hFFF];
            m_pc = (m_cnt == 2) ? {w, m_pc[15:0]} : {m_pc[31:16], w};
            m_cnt--;
            m_ins = BUBBLE_INSTR; m_v = 0;
         end else begin
`ifdef INT_RET_PC_EN
            if (bus.int_inject && !m_prev && !bus.flush && !bus.stall) m_ret = m_pc;
`endif
            if (bus.flush) begin
               m_pc = bus.branch_target; m_ins = BUBBLE_INSTR; m_v = 0;
            end else if (bus.int_to_fetch) begin
               m_cnt = 2; m_base = 20'h2; m_ins = BUBBLE_INSTR; m_v = 0;
            end else if (!bus.stall) begin
               m_ins = bus.int_inject ? bus.int_instr : mem[m_pc[11:0]];
               m_ipc = m_pc; m_v = 1;
               if (!bus.int_inject) m_pc = m_pc + 1;
            end
         end
         m_prev = bus.int_inject;
      end
   endtask

   initial begin
      logic [31:0] exp_ret;
`ifdef INT_RET_PC_EN
      exp_ret = 32'h30;
`else
      exp_ret = 32'h0;
`endif
      for (int i = 0; i < 4096; i++) mem[i] = 16'(16'hA103 + i);
      mem[0] = 16'h0000; mem[1] = 16'h0020; mem[2] = 16'h0000; mem[3] = 16'h0100;
      tv[0]  = '{0, 0, 0,     0, 0,        0, 20'h0,   BUBBLE_INSTR, 0,     0};
      tv[1]  = '{0, 0, 0,     0, 0,        0, 20'h1,   BUBBLE_INSTR, 0,     0};
      tv[2]  = '{0, 0, 0,     0, 0,        0, 20'h20,  16'hA123,     32'h20, 1};
      tv[3]  = '{1, 0, 0,     0, 0,        0, 20'h21,  16'hA123,     32'h20, 1};
      tv[4]  = '{1, 0, 0,     0, 0,        0, 20'h21,  16'hA123,     32'h20, 1};
      tv[5]  = '{1, 0, 0,     0, 0,        0, 20'h21,  16'hA123,     32'h20, 1};
      tv[6]  = '{0, 0, 0,     0, 0,        0, 20'h21,  16'hA124,     32'h21, 1};
      tv[7]  = '{0, 0, 0,     0, 0,        0, 20'h22,  16'hA125,     32'h22, 1};
      tv[8]  = '{0, 0, 0,     0, 0,        0, 20'h23,  16'hA126,     32'h23, 1};
      tv[9]  = '{0, 0, 0,     0, 0,        0, 20'h24,  16'hA127,     32'h24, 1};
      tv[10] = '{1, 1, 32'h40, 0, 0,       0, 20'h25,  BUBBLE_INSTR, 0,     0};
      tv[11] = '{0, 0, 0,     0, 0,        0, 20'h40,  16'hA143,     32'h40, 1};
      tv[12] = '{0, 1, 32'h30, 0, 0,       0, 20'h41,  BUBBLE_INSTR, 0,     0};
      tv[13] = '{0, 0, 0,     1, 16'h07F8, 0, 20'h30,  16'h07F8,     32'h30, 1};
      tv[14] = '{0, 0, 0,     1, 16'hF480, 0, 20'h30,  16'hF480,     32'h30, 1};
      tv[15] = '{0, 0, 0,     1, 16'hC000, 0, 20'h30,  16'hC000,     32'h30, 1};
      tv[16] = '{0, 0, 0,     0, 0,        0, 20'h30,  16'hA133,     32'h30, 1};
      tv[17] = '{0, 0, 0,     0, 0,        1, 20'h31,  BUBBLE_INSTR, 0,     0};
      tv[18] = '{0, 1, 32'h77, 0, 0,       0, 20'h2,   BUBBLE_INSTR, 0,     0};
      tv[19] = '{0, 0, 0,     0, 0,        0, 20'h3,   BUBBLE_INSTR, 0,     0};
      tv[20] = '{0, 0, 0,     0, 0,        0, 20'h100, 16'hA203,     32'h100, 1};
      drive(1, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr", 32'(bus.if_instr), 32'(BUBBLE_INSTR));
      chk("rst_pc", bus.if_pc, 0);
      chk("rst_valid", 32'(bus.if_valid), 0);
      chk("rst_ret", bus.int_ret_pc, 0);
      chk("rst_addr", 32'(bus.imem_addr), 0);
      @(negedge clk);
      for (int i = 0; i < 21; i++) begin
         drive(0, tv[i].stall, tv[i].flush, tv[i].tgt, tv[i].inj, tv[i].ins, tv[i].tf);
         #1 chk($sformatf("tv%0d_addr", i), 32'(bus.imem_addr), 32'(tv[i].addr));
         @(posedge clk);
         #1;
         chk($sformatf("tv%0d_instr", i), 32'(bus.if_instr), 32'(tv[i].e_ins));
         chk($sformatf("tv%0d_valid", i), 32'(bus.if_valid), 32'(tv[i].e_v));
         if (tv[i].e_v) chk($sformatf("tv%0d_pc", i), bus.if_pc, tv[i].e_pc);
         @(negedge clk);
      end
      chk("ret_pc", bus.int_ret_pc, exp_ret);
      // reset while the IVT load is half done
      drive(0, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk) rst = 1;
      #1 chk("t6_veclo_addr", 32'(bus.imem_addr), 3);
      @(posedge clk);
      #1;
      chk("t6_instr", 32'(bus.if_instr), 32'(BUBBLE_INSTR));
      chk("t6_valid", 32'(bus.if_valid), 0);
      chk("t6_pc", bus.if_pc, 0);
      chk("t6_ret", bus.int_ret_pc, 0);
      @(negedge clk) rst = 0;
      #1 chk("t6_boot_addr", 32'(bus.imem_addr), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t6_first_instr", 32'(bus.if_instr), 32'hA123);
      chk("t6_first_pc", bus.if_pc, 32'h20);
      chk("t6_first_valid", 32'(bus.if_valid), 1);
      // pc wraps from all-ones to zero
      @(negedge clk);
      mem[0] = 16'hFFFF; mem[1] = 16'hFFFF;
      rst = 1;
      @(posedge clk);
      @(negedge clk) rst = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("wrap_pc_hi", bus.if_pc, 32'hFFFF_FFFF);
      chk("wrap_instr_hi", 32'(bus.if_instr), 32'hB102);
      @(posedge clk);
      #1;
      chk("wrap_pc_zero", bus.if_pc, 0);
      chk("wrap_instr_zero", 32'(bus.if_instr), 32'hFFFF);
      for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h0; mem[1] = 16'($urandom_range(16, 3840));
      mem[2] = 16'h0; mem[3] = 16'($urandom_range(16, 3840));
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         drive(n == 0 || $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
               32'($urandom_range(0, 4095)), $urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 15) == 0);
         #1;
         if (n > 0) chk("rnd_addr", 32'(bus.imem_addr), 32'(m_addr()));
         model_step();
         @(posedge clk);
         #1;
         chk("rnd_instr", 32'(bus.if_instr), 32'(m_ins));
         chk("rnd_valid", 32'(bus.if_valid), 32'(m_v));
         if (m_v) chk("rnd_pc", bus.if_pc, m_ipc);
         chk("rnd_ret", bus.int_ret_pc, m_ret);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
